reg_write_arbiter: RTL and testbench

Shares the register bank's single write port among several producers (ALU writeback, load unit, debug/init port) with round-robin arbitration and a valid/ready handshake. It also holds a per-register busy scoreboard: issue logic reserves a destination register, and the bit clears when that register's write commits, so read logic can stall on pending results. It sits between the producers and `reg_bank`, driving `write_enable`, `write_addr` and `write_data`.

---
 rtl/redux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/reg_write_arbiter.sv | 94 +++++++++
 tb/tb_reg_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/redux_pkg.sv
// Shared constants for the register-bank write path.
//   DATA_W / ADDR_W / NUM_REG : register geometry
//   REQ_ALU / REQ_LOAD / REQ_DBG : requester slot on the shared write port
package redux_pkg;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int NUM_REG = 2 ** ADDR_W;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;
  localparam int NUM_REQ  = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after
// rr_ptr (wrapping). The pointer moves past the winner when advance is high.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector
//   advance    : a grant was taken this cycle
//   grant      : one-hot grant, combinational
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (advance && found)
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register bank's single write port among NUM_REQ producers and
// tracks pending destinations in a per-register busy scoreboard.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/addr/data : packed producer requests (slot i at [i*W +: W])
//   req_ready           : one-hot combinational grant
//   rf_write_*          : registered write port to reg_bank (1-cycle pulse)
//   reserve_valid/addr  : issue logic reserving a destination
//   reserve_ready       : destination not busy, combinational
//   busy                : registered scoreboard bits
module reg_write_arbiter #(
  parameter int NUM_REQ = redux_pkg::NUM_REQ,
  parameter int DATA_W  = redux_pkg::DATA_W,
  parameter int ADDR_W  = redux_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_addr,
  output logic                      reserve_ready,
  output logic [(2**ADDR_W)-1:0]    busy
);
  import redux_pkg::*;

  localparam int NREG = 2 ** ADDR_W;

  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               reserve_acc;
  logic [NREG-1:0]    busy_nxt;

  // Requests are masked during reset so nothing is granted or transferred.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid & {NUM_REQ{~reset}}),
    .advance (xfer),
    .grant   (grant)
  );

  assign req_ready = grant;
  // grant is already qualified by valid, so any grant bit is a transfer.
  assign xfer      = |grant;

  // One-hot AND-OR mux of the winning request.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= xfer;
      if (xfer) begin
        rf_write_addr <= sel_addr;
        rf_write_data <= sel_data;
      end
    end
  end

  assign reserve_ready = ~reset & ~busy[reserve_addr];
  assign reserve_acc   = reserve_valid & reserve_ready;

  // Clear on commit first, then set on reserve, so a new reservation of the
  // register being committed wins and the bit stays pending.
  always_comb begin
    busy_nxt = busy;
    if (rf_write_enable) busy_nxt[rf_write_addr] = 1'b0;
    if (reserve_acc)     busy_nxt[reserve_addr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rf_write_enable;
  logic [ADDR_W-1:0]         rf_write_addr;
  logic [DATA_W-1:0]         rf_write_data;
  logic                      reserve_valid;
  logic [ADDR_W-1:0]         reserve_addr;
  logic                      reserve_ready;
  logic [3:0]                busy;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] bank [4];

  always #5 clk = ~clk;

  reg_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .reserve_valid   (reserve_valid),
    .reserve_addr    (reserve_addr),
    .reserve_ready   (reserve_ready),
    .busy            (busy)
  );

  // Minimal reg_bank: captures a write on the edge where the pulse is high.
  always @(posedge clk) if (rf_write_enable) bank[rf_write_addr] <= rf_write_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 3'b111;
    req_addr = {2'd2, 2'd1, 2'd0};
    req_data = {8'h12, 8'h11, 8'h10};
    reserve_valid = 1'b0;
    reserve_addr = 2'd0;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_we", 32'(rf_write_enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr", 32'(rf_write_addr), 32'h0);
    chk("rst_data", 32'(rf_write_data), 32'h0);
    chk("rst_reserve_ready", 32'(reserve_ready), 32'h0);
    step();
    reset = 1'b0;
    #1;

    // Fairness: all three valid, grants rotate 0,1,2,0,1,2 from reset pointer.
    for (int n = 0; n < 6; n++) begin
      chk("fair_grant", 32'(req_ready), 32'(3'b001 << (n % 3)));
      step();
      chk("fair_we", 32'(rf_write_enable), 32'h1);
      chk("fair_addr", 32'(rf_write_addr), 32'(n % 3));
      chk("fair_data", 32'(rf_write_data), 32'(8'h10 + (n % 3)));
    end
    req_valid = 3'b000;
    #1;
    chk("idle_ready", 32'(req_ready), 32'h0);
    step();
    chk("idle_we", 32'(rf_write_enable), 32'h0);
    chk("idle_addr_hold", 32'(rf_write_addr), 32'h2);
    chk("idle_data_hold", 32'(rf_write_data), 32'h12);

    // Single write: load unit writes A5 to addr 2 (pointer is back at 0).
    req_valid = 3'b010;
    req_addr = {2'd0, 2'd2, 2'd0};
    req_data = {8'h00, 8'hA5, 8'h00};
    #1;
    chk("single_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    chk("single_we", 32'(rf_write_enable), 32'h1);
    chk("single_addr", 32'(rf_write_addr), 32'h2);
    chk("single_data", 32'(rf_write_data), 32'hA5);
    step();
    chk("single_we_off", 32'(rf_write_enable), 32'h0);
    chk("bank_read", 32'(bank[2]), 32'hA5);

    // Scoreboard: reserve 3, reserve refused while busy, ALU write clears it.
    reserve_valid = 1'b1;
    reserve_addr = 2'd3;
    #1;
    chk("resv_ready", 32'(reserve_ready), 32'h1);
    step();
    chk("resv_busy", 32'(busy), 32'h8);
    chk("resv_again_ready", 32'(reserve_ready), 32'h0);
    step();
    reserve_valid = 1'b0;
    chk("resv_refused_busy", 32'(busy), 32'h8);
    // Pointer is 2; only ALU valid, so the grant wraps to requester 0.
    req_valid = 3'b001;
    req_addr = {2'd0, 2'd0, 2'd3};
    req_data = {8'h00, 8'h00, 8'h77};
    #1;
    chk("alu_grant_wrap", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    chk("alu_we", 32'(rf_write_enable), 32'h1);
    chk("alu_busy_pending", 32'(busy), 32'h8);
    step();
    chk("alu_commit_busy", 32'(busy), 32'h0);
    chk("alu_bank", 32'(bank[3]), 32'h77);

    // Reserve lands on the commit cycle of an untracked write to addr 1:
    // reservation accepted, commit must not clear it.
    req_valid = 3'b001;
    req_addr = {2'd0, 2'd0, 2'd1};
    req_data = {8'h00, 8'h00, 8'h5A};
    #1;
    step();
    req_valid = 3'b000;
    reserve_valid = 1'b1;
    reserve_addr = 2'd1;
    #1;
    chk("sim_we", 32'(rf_write_enable), 32'h1);
    chk("sim_resv_ready", 32'(reserve_ready), 32'h1);
    step();
    reserve_valid = 1'b0;
    chk("sim_busy_kept", 32'(busy), 32'h2);
    // Commit to busy addr 1 with a refused reserve: the bit clears.
    req_valid = 3'b100;
    req_addr = {2'd1, 2'd0, 2'd0};
    req_data = {8'h66, 8'h00, 8'h00};
    #1;
    chk("dbg_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = 3'b000;
    reserve_valid = 1'b1;
    #1;
    chk("dbg_resv_refused", 32'(reserve_ready), 32'h0);
    step();
    reserve_valid = 1'b0;
    chk("dbg_commit_busy", 32'(busy), 32'h0);

    // Reset mid-operation: grant, then reset during the pulse cycle.
    reserve_valid = 1'b1;
    reserve_addr = 2'd0;
    step();
    reserve_valid = 1'b0;
    chk("mid_busy_set", 32'(busy), 32'h1);
    req_valid = 3'b010;
    req_addr = {2'd0, 2'd3, 2'd0};
    req_data = {8'h00, 8'h99, 8'h00};
    #1;
    chk("mid_grant", 32'(req_ready), 32'h2);
    step();
    reset = 1'b1;
    #1;
    chk("mid_ready_in_reset", 32'(req_ready), 32'h0);
    step();
    chk("mid_we_cleared", 32'(rf_write_enable), 32'h0);
    chk("mid_busy_cleared", 32'(busy), 32'h0);
    chk("mid_addr_cleared", 32'(rf_write_addr), 32'h0);
    // Pointer was at 2 before reset; after release, requester 0 wins first.
    req_valid = 3'b111;
    reset = 1'b0;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
